// File: rtl/mips_pipe_pkg.sv
// mips_pipe_pkg: shared constants and next-PC select encoding for the MIPS pipeline
package mips_pipe_pkg;
  localparam logic [31:0] RESET_PC  = 32'h0040_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  typedef enum logic [2:0] {PCSEL_SEQ, PCSEL_BR, PCSEL_JR, PCSEL_J, PCSEL_HOLD} pcsel_e;
endpackage

// File: rtl/if_stage_pipe_if.sv
// if_stage_pipe_if: hazard controls, redirect targets, imem data and IF/ID outputs of the fetch stage
// master = hazard/decode/memory side, slave = if_stage_pipe
// IF_PERF_CNT_EN adds StallCount/FlushCount outputs
interface if_stage_pipe_if #(parameter int DATA_WIDTH = 32);
  logic                  PCHold, IFIDHold, BranchTaken, Jump, JR;
  logic [DATA_WIDTH-1:0] BranchTarget, JumpTarget, JRTarget, InstrIn;
  logic [DATA_WIDTH-1:0] PC, IF_ID_Instr, IF_ID_PC4;
  logic                  IF_ID_Valid, Redirect;
`ifdef IF_PERF_CNT_EN
  logic [31:0]           StallCount, FlushCount;
`endif
  modport master (
    output PCHold, IFIDHold, BranchTaken, BranchTarget, Jump, JumpTarget, JR, JRTarget, InstrIn,
    input  PC, IF_ID_Instr, IF_ID_PC4, IF_ID_Valid, Redirect
`ifdef IF_PERF_CNT_EN
    , StallCount, FlushCount
`endif
  );
  modport slave (
    input  PCHold, IFIDHold, BranchTaken, BranchTarget, Jump, JumpTarget, JR, JRTarget, InstrIn,
    output PC, IF_ID_Instr, IF_ID_PC4, IF_ID_Valid, Redirect
`ifdef IF_PERF_CNT_EN
    , StallCount, FlushCount
`endif
  );
endinterface

// File: rtl/if_stage_pipe_pc_next_sel.sv
// pc_next_sel: priority mux choosing next PC (branch > hold > JR > jump > PC+4) and flagging redirects
// in: pc, pc4, pc_hold, branch/jr/jump requests and targets; out: next_pc, redirect
module pc_next_sel
  import mips_pipe_pkg::*;
#(parameter int DATA_WIDTH = 32) (
  input  logic [DATA_WIDTH-1:0] pc,
  input  logic [DATA_WIDTH-1:0] pc4,
  input  logic                  pc_hold,
  input  logic                  branch_taken,
  input  logic [DATA_WIDTH-1:0] branch_target,
  input  logic                  jr,
  input  logic [DATA_WIDTH-1:0] jr_target,
  input  logic                  jump,
  input  logic [DATA_WIDTH-1:0] jump_target,
  output logic [DATA_WIDTH-1:0] next_pc,
  output logic                  redirect
);
  pcsel_e sel;
  always_comb begin
    // a resolved branch is older than whatever is stalled, so it beats the hold
    sel = branch_taken ? PCSEL_BR : pc_hold ? PCSEL_HOLD : jr ? PCSEL_JR : jump ? PCSEL_J : PCSEL_SEQ;
    next_pc = (sel == PCSEL_BR)   ? branch_target :
              (sel == PCSEL_HOLD) ? pc :
              (sel == PCSEL_JR)   ? jr_target :
              (sel == PCSEL_J)    ? jump_target : pc4;
    redirect = branch_taken | (!pc_hold & (jr | jump));
  end
endmodule

// File: rtl/if_stage_pipe.sv
// if_stage_pipe: MIPS instruction-fetch stage with PC register and IF/ID pipeline register
// ports: clk, reset (async active-high), bus (if_stage_pipe_if.slave: controls, targets, InstrIn in; PC, IF/ID, Redirect out)
// IF_PERF_CNT_EN: adds saturating StallCount/FlushCount
module if_stage_pipe #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = mips_pipe_pkg::RESET_PC,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = mips_pipe_pkg::NOP_INSTR
) (
  input logic            clk,
  input logic            reset,
  if_stage_pipe_if.slave bus
);
  logic [DATA_WIDTH-1:0] pc_q, pc_d, instr_q, instr_d, pc4_q, pc4_d, pc4, next_pc;
  logic                  valid_q, valid_d, redirect;
  assign pc4 = pc_q + DATA_WIDTH'(4);
  pc_next_sel #(.DATA_WIDTH(DATA_WIDTH)) u_sel (
    .pc(pc_q), .pc4(pc4), .pc_hold(bus.PCHold),
    .branch_taken(bus.BranchTaken), .branch_target(bus.BranchTarget),
    .jr(bus.JR), .jr_target(bus.JRTarget),
    .jump(bus.Jump), .jump_target(bus.JumpTarget),
    .next_pc(next_pc), .redirect(redirect)
  );
  always_comb begin
    pc_d    = next_pc;
    // flush beats hold: the fetched instruction is on the wrong path
    instr_d = redirect ? NOP_INSTR : bus.IFIDHold ? instr_q : bus.InstrIn;
    pc4_d   = redirect ? '0 : bus.IFIDHold ? pc4_q : pc4;
    valid_d = !redirect && (bus.IFIDHold ? valid_q : 1'b1);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end
  assign bus.PC          = pc_q;
  assign bus.IF_ID_Instr = instr_q;
  assign bus.IF_ID_PC4   = pc4_q;
  assign bus.IF_ID_Valid = valid_q;
  assign bus.Redirect    = redirect;
`ifdef IF_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  always_comb begin
    // a taken branch overrides the hold, so that cycle is not a stall
    stall_cnt_d = (bus.PCHold && !bus.BranchTaken && !(&stall_cnt_q)) ? stall_cnt_q + 32'd1 : stall_cnt_q;
    flush_cnt_d = (redirect && !(&flush_cnt_q)) ? flush_cnt_q + 32'd1 : flush_cnt_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
  assign bus.StallCount = stall_cnt_q;
  assign bus.FlushCount = flush_cnt_q;
`endif
endmodule

// File: tb/tb_if_stage_pipe.sv
// tb_if_stage_pipe: directed self-checking bench for if_stage_pipe
module tb_if_stage_pipe;
  logic clk;
  logic reset;
  int checks;
  int errors;
  if_stage_pipe_if #(.DATA_WIDTH(32)) b ();
  if_stage_pipe dut (.clk(clk), .reset(reset), .bus(b));
  assign b.InstrIn = b.PC ^ 32'hDEAD_0000;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctl();
    b.PCHold = 0; b.IFIDHold = 0; b.BranchTaken = 0; b.Jump = 0; b.JR = 0;
    b.BranchTarget = 0; b.JumpTarget = 0; b.JRTarget = 0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic test_reset();
    clear_ctl();
    reset = 1'b1;
    step();
    chk("rst_pc", b.PC, 32'h0040_0000);
    chk("rst_instr", b.IF_ID_Instr, 32'h0);
    chk("rst_pc4", b.IF_ID_PC4, 32'h0);
    chk("rst_valid", {31'b0, b.IF_ID_Valid}, 32'd0);
    reset = 1'b0;
    #2;
    chk("rel_pc", b.PC, 32'h0040_0000);
  endtask

  task automatic test_sequential();
    step();
    chk("seq1_pc", b.PC, 32'h0040_0004);
    chk("seq1_instr", b.IF_ID_Instr, 32'hDEED_0000);
    chk("seq1_pc4", b.IF_ID_PC4, 32'h0040_0004);
    chk("seq1_valid", {31'b0, b.IF_ID_Valid}, 32'd1);
    step();
    chk("seq2_pc", b.PC, 32'h0040_0008);
    chk("seq2_pc4", b.IF_ID_PC4, 32'h0040_0008);
    chk("seq2_redirect", {31'b0, b.Redirect}, 32'd0);
  endtask

  task automatic test_stall();
    step();
    step();
    chk("pre_stall_pc", b.PC, 32'h0040_0010);
    b.PCHold = 1; b.IFIDHold = 1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("stall_pc", b.PC, 32'h0040_0010);
      chk("stall_pc4", b.IF_ID_PC4, 32'h0040_0010);
      chk("stall_instr", b.IF_ID_Instr, 32'hDEED_000C);
    end
    clear_ctl();
    step();
    chk("resume_pc", b.PC, 32'h0040_0014);
    chk("resume_instr", b.IF_ID_Instr, 32'hDEED_0010);
  endtask

  task automatic test_branch();
    b.BranchTaken = 1; b.BranchTarget = 32'h0040_0100; b.PCHold = 1;
    #1;
    chk("br_redirect", {31'b0, b.Redirect}, 32'd1);
    step();
    chk("br_pc", b.PC, 32'h0040_0100);
    chk("br_instr", b.IF_ID_Instr, 32'h0);
    chk("br_valid", {31'b0, b.IF_ID_Valid}, 32'd0);
    chk("br_pc4", b.IF_ID_PC4, 32'h0);
    clear_ctl();
  endtask

  task automatic test_jump();
    b.Jump = 1; b.JumpTarget = 32'h0040_0040; b.PCHold = 1; b.IFIDHold = 1;
    #1;
    chk("j_hold_redirect", {31'b0, b.Redirect}, 32'd0);
    step();
    chk("j_hold_pc", b.PC, 32'h0040_0100);
    b.PCHold = 0; b.IFIDHold = 0;
    #1;
    chk("j_redirect", {31'b0, b.Redirect}, 32'd1);
    step();
    chk("j_pc", b.PC, 32'h0040_0040);
    chk("j_valid", {31'b0, b.IF_ID_Valid}, 32'd0);
    clear_ctl();
  endtask

  task automatic test_jr_jump();
    b.JR = 1; b.JRTarget = 32'h0040_0200; b.Jump = 1; b.JumpTarget = 32'h0040_0040;
    step();
    chk("jrj_pc", b.PC, 32'h0040_0200);
    clear_ctl();
  endtask

  task automatic test_wrap();
    b.JR = 1; b.JRTarget = 32'hFFFF_FFFC;
    step();
    chk("wrap_pre_pc", b.PC, 32'hFFFF_FFFC);
    clear_ctl();
    step();
    chk("wrap_pc", b.PC, 32'h0000_0000);
    chk("wrap_instr", b.IF_ID_Instr, 32'h2152_FFFC);
    chk("wrap_pc4", b.IF_ID_PC4, 32'h0000_0000);
    chk("wrap_valid", {31'b0, b.IF_ID_Valid}, 32'd1);
  endtask

`ifdef IF_PERF_CNT_EN
  task automatic test_perf();
    chk("perf_stall", b.StallCount, 32'd3);
    chk("perf_flush", b.FlushCount, 32'd4);
  endtask
`endif

  task automatic test_async_reset();
    b.BranchTaken = 1; b.BranchTarget = 32'h0000_1000; b.PCHold = 1;
    #2;
    reset = 1'b1;
    #1;
    chk("ar_pc", b.PC, 32'h0040_0000);
    chk("ar_instr", b.IF_ID_Instr, 32'h0);
    chk("ar_valid", {31'b0, b.IF_ID_Valid}, 32'd0);
    chk("ar_pc4", b.IF_ID_PC4, 32'h0);
`ifdef IF_PERF_CNT_EN
    chk("ar_stall_cnt", b.StallCount, 32'd0);
    chk("ar_flush_cnt", b.FlushCount, 32'd0);
`endif
    clear_ctl();
    step();
    reset = 1'b0;
    step();
    chk("ar_after_pc", b.PC, 32'h0040_0004);
    chk("ar_after_instr", b.IF_ID_Instr, 32'hDEED_0000);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_jump();
    test_jr_jump();
    test_wrap();
`ifdef IF_PERF_CNT_EN
    test_perf();
`endif
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
